// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter.
//   state_t       : FSM encoding (IDLE, EXEC, HOLD)
//   OP_ADD/OP_SUB : values of the reqN_select operation bit
//   DEFAULT_WIDTH : default operand/result width
package addsub_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder/subtractor.
//   a, b   : operands
//   select : 0 = a + b, 1 = a - b (computed as a + ~b + 1)
//   s      : result modulo 2^WIDTH
//   cout   : carry out of the MSB (for subtraction, 1 = no borrow)
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_x;

  // Inverting b and injecting select as the carry-in gives a + ~b + 1.
  assign b_x      = b ^ {WIDTH{select}};
  assign carry[0] = select;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign s[gi]       = a[gi] ^ b_x[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared adder/subtractor.
// A granted request is latched (IDLE -> EXEC), computed and registered
// (EXEC -> HOLD), then held until the consumer accepts it (HOLD -> IDLE).
//   clk, reset          : clock, synchronous active-high reset
//   reqN_valid/ready    : request handshake for requester N (0 or 1)
//   reqN_a/b/select     : operands and op (0 add, 1 subtract)
//   result_valid/ready  : result handshake
//   result_id           : requester owning the held result
//   s, cout, ovf        : result, carry-out, signed overflow
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_select,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_select,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             result_id,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sel_q, id_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q, rid_q;

  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             ovf_calc;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .s      (add_s),
    .cout   (add_cout),
    .a      (a_q),
    .b      (b_q),
    .select (sel_q)
  );

  // Single valid requester wins outright; a tie goes to the one that did
  // not win last time.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
  end

  assign req0_ready = !reset && (state_q == IDLE) && !grant;
  assign req1_ready = !reset && (state_q == IDLE) &&  grant;
  assign xfer       = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  // Signed overflow: for subtraction the effective second operand is ~b,
  // so the sign-equality test is inverted.
  always_comb begin
    ovf_calc = 1'b0;
    if (sel_q == OP_ADD)
      ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
    else
      ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= 1'b0;
      id_q         <= 1'b0;
      s_q          <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rid_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        a_q          <= grant ? req1_a : req0_a;
        b_q          <= grant ? req1_b : req0_b;
        sel_q        <= grant ? req1_select : req0_select;
        id_q         <= grant;
        last_grant_q <= grant;
      end
      if (state_q == EXEC) begin
        s_q    <= add_s;
        cout_q <= add_cout;
        ovf_q  <= ovf_calc;
        rid_q  <= id_q;
      end
    end
  end

  assign result_valid = (state_q == HOLD);
  assign result_id    = rid_q;
  assign s            = s_q;
  assign cout         = cout_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_select, req1_select;
  logic         result_valid, result_ready, result_id;
  logic [W-1:0] s;
  logic         cout, ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_select  (req0_select),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_select  (req1_select),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .s            (s),
    .cout         (cout),
    .ovf          (ovf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the sampling point just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until the given requester is granted.
  task automatic wait_ready(input bit id, input string tag);
    int n;
    n = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 8'((id ? req1_ready : req0_ready)), 8'd1);
  endtask

  // One complete transaction on requester id with result_ready high.
  task automatic do_op(input string tag, input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sel,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_select = sel; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_select = sel; end
    #1;
    wait_ready(id, tag);
    step();                 // transfer edge passed, now in EXEC
    if (id) req1_valid = 0; else req0_valid = 0;
    #1;
    chk({tag, "_exec_rv"}, 8'(result_valid), 8'd0);
    chk({tag, "_exec_rdy"}, 8'({req1_ready, req0_ready}), 8'd0);
    step();                 // now in HOLD
    chk({tag, "_rv"}, 8'(result_valid), 8'd1);
    chk({tag, "_s"}, 8'(s), 8'(es));
    chk({tag, "_cout"}, 8'(cout), 8'(ec));
    chk({tag, "_ovf"}, 8'(ovf), 8'(eo));
    chk({tag, "_id"}, 8'(result_id), 8'(id));
    $display("op %s id=%0d a=%0d b=%0d sel=%0d -> s=%0h cout=%0d ovf=%0d", tag, id, a, b, sel, s, cout, ovf);
    step();                 // accepted, back to IDLE
  endtask

  initial begin
    reset = 1; result_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_select = 0;
    req1_a = 0; req1_b = 0; req1_select = 0;
    step();
    req0_valid = 1; req1_valid = 1; #1;
    chk("rst_ready", 8'({req1_ready, req0_ready}), 8'd0);
    req0_valid = 0; req1_valid = 0;
    step();
    reset = 0; #1;
    chk("rst_rv", 8'(result_valid), 8'd0);
    chk("rst_s", 8'(s), 8'd0);
    chk("rst_flags", 8'({cout, ovf, result_id}), 8'd0);
    chk("rst_idle", 8'({req1_ready, req0_ready}), 8'b01);

    // Basic operations
    do_op("add_2_5",  1'b0, 4'd2, 4'd5,  1'b0, 4'd7,     1'b0, 1'b0);
    do_op("sub_7_2",  1'b1, 4'd7, 4'd2,  1'b1, 4'd5,     1'b1, 1'b0);
    do_op("sub_3_5",  1'b1, 4'd3, 4'd5,  1'b1, 4'b1110,  1'b0, 1'b0);
    do_op("sub_1_10", 1'b1, 4'd1, 4'd10, 1'b1, 4'd7,     1'b0, 1'b0);

    // Tie straight after reset, both held valid for four operations
    reset = 1; step(); reset = 0;
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_select = 0;
    req1_valid = 1; req1_a = 4'd4; req1_b = 4'd3; req1_select = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      bit eid;
      eid = bit'(i % 2);
      wait_ready(eid, $sformatf("tie%0d", i));
      step(); step();
      chk($sformatf("tie%0d_rv", i), 8'(result_valid), 8'd1);
      chk($sformatf("tie%0d_id", i), 8'(result_id), 8'(eid));
      chk($sformatf("tie%0d_s", i), 8'(s), eid ? 8'd1 : 8'd2);
      $display("op tie%0d id=%0d s=%0h", i, result_id, s);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // Back-pressure: 5+5 held while req1 waits
    result_ready = 0;
    req0_valid = 1; req0_a = 4'd5; req0_b = 4'd5; req0_select = 0; #1;
    wait_ready(1'b0, "hold");
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 4'd1; req1_b = 4'd10; req1_select = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d_rv", i), 8'(result_valid), 8'd1);
      chk($sformatf("hold%0d_res", i), 8'({s, cout, ovf}), 8'({4'd10, 1'b0, 1'b1}));
      chk($sformatf("hold%0d_rdy", i), 8'({req1_ready, req0_ready}), 8'd0);
      step();
    end
    $display("op hold id=%0d s=%0h cout=%0d ovf=%0d", result_id, s, cout, ovf);
    result_ready = 1;
    step();                 // back in IDLE, waiting req1 now granted
    chk("hold_req1_ready", 8'(req1_ready), 8'd1);
    step();
    req1_valid = 0;
    step();
    chk("waited_rv", 8'(result_valid), 8'd1);
    chk("waited_res", 8'({s, cout, ovf, result_id}), 8'({4'd7, 1'b0, 1'b0, 1'b1}));
    $display("op waited id=%0d s=%0h", result_id, s);
    step();

    // Reset during EXEC discards the operation
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4; req0_select = 0; #1;
    wait_ready(1'b0, "rexec");
    step();                 // in EXEC
    req0_valid = 0; reset = 1; #1;
    chk("rexec_rdy_in_rst", 8'({req1_ready, req0_ready}), 8'd0);
    step();
    reset = 0; #1;
    chk("rexec_rv", 8'(result_valid), 8'd0);
    chk("rexec_s", 8'(s), 8'd0);
    chk("rexec_idle", 8'(req0_ready), 8'd1);
    step();
    chk("rexec_rv2", 8'(result_valid), 8'd0);
    do_op("after_rst", 1'b0, 4'd6, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when req0_valid also high.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_select  input  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_select: same as REQ-004..007, for requester 1.
REQ-009 result_valid  output  1  result registers hold a valid result.
REQ-010 result_ready  input  1  consumer accepts the result this cycle.
REQ-011 result_id  output  1  index of the requester that owns the result.
REQ-012 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 cout  output  1  adder carry-out; for subtraction 1 means a >= b unsigned (no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and HOLD.
REQ-016 IDLE: reqN_ready SHALL be 1 only for the granted requester; a transfer occurs when the granted reqN_valid and reqN_ready are both 1.
REQ-017 On transfer, a, b, select and requester id SHALL be latched into operand registers and the FSM SHALL go to EXEC.
REQ-018 EXEC: the shared adder SHALL evaluate the latched operands; s, cout, ovf and result_id SHALL be registered at the clock edge ending EXEC, and the FSM SHALL go to HOLD.
REQ-019 HOLD: result_valid SHALL be 1 and all result outputs SHALL stay stable until result_valid and result_ready are both 1, after which the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be 2 cycles, from the transfer edge to result_valid high; with result_ready tied high, throughput SHALL be one operation per 3 cycles.
REQ-021 reqN_ready SHALL be 0 in EXEC and HOLD; a valid request waiting in those states SHALL not be lost and SHALL be served later.
REQ-022 Arbitration SHALL be round-robin over a last_grant bit: when only one requester is valid, it wins; when both are valid, the requester not equal to last_grant wins.
REQ-023 last_grant SHALL update only on a transfer.
REQ-024 Subtraction SHALL be computed as a + ~b + 1 through the shared adder's select input.
REQ-025 ovf SHALL be computed as follows: add: a[MSB]==b[MSB] and s[MSB]!=a[MSB]; subtract: a[MSB]!=b[MSB] and s[MSB]!=a[MSB].
REQ-026 A request whose valid drops before it is granted SHALL be ignored, with no side effect.

Reset
REQ-027 When reset is 1 at a clock edge: state=IDLE, result_valid=0, s=0, cout=0, ovf=0, result_id=0, operand registers=0, last_grant=1 (requester 0 wins the first tie).
REQ-028 Reset SHALL take priority over any handshake in the same cycle; an operation in EXEC or HOLD SHALL be discarded with no result produced.
REQ-029 req0_ready and req1_ready SHALL be 0 while reset is asserted.

Structure
REQ-030 Shared package SHALL hold the state encoding (IDLE=2'd0, EXEC=2'd1, HOLD=2'd2), the op codes OP_ADD=0 and OP_SUB=1, and the default WIDTH.
REQ-031 Exactly one instance of the existing ripple_carry_adder (ports s, cout, a, b, select) SHALL be used as the sole arithmetic resource.
REQ-032 Arbitration, FSM and result registers SHALL be local to addsub_arbiter; no other sub-modules.

Verification
REQ-033 req0: a=2, b=5, select=0, result_ready=1 -> result_valid 2 cycles after transfer; s=7, cout=0, ovf=0, result_id=0.
REQ-034 req1: a=7, b=2, select=1 -> s=5, cout=1, ovf=0, result_id=1; then req1: a=3, b=5, select=1 -> s=4'b1110, cout=0, ovf=0.
REQ-035 req0 and req1 valid in the same cycle, straight after reset -> req0 served first, then req1 (result_id 0 then 1); repeat the test -> order alternates according to last_grant.
REQ-036 req0: a=5, b=5, select=0 with result_ready=0 for 4 cycles -> s=10, cout=0, ovf=1 held stable; req ready stays 0 until result_ready rises.
REQ-037 req1: a=1, b=10, select=1 -> s=7, cout=0, ovf=0.
REQ-038 reset pulsed during EXEC -> next cycle result_valid=0, state IDLE, no stale result; a new request then completes normally.
